mul_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit for the pipeline's execute stage. It sits beside the single-cycle ALU and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU iteratively, one bit per cycle, and handles MTHI/MTLO writes.
- Uses a start/busy/done handshake. The hazard unit stalls on busy_o, and MFHI/MFLO read hi_o/lo_o directly.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mul_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit and its clients
// (decoder and hazard unit).
package mdu_pkg;

   localparam int unsigned MDU_WIDTH = 32;

   // Operation codes driven by the decoder; 6 and 7 are reserved.
   typedef enum logic [2:0] {
      OpMult  = 3'd0,
      OpMultu = 3'd1,
      OpDiv   = 3'd2,
      OpDivu  = 3'd3,
      OpMthi  = 3'd4,
      OpMtlo  = 3'd5
   } mdu_op_t;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFinish
   } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle,
// with a start/busy/done handshake and cancel on pipeline flush.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cancel_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   mdu_state_t       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   // acc: upper partial product (mult) or partial remainder (div).
   logic [WIDTH:0]   acc_q, acc_d;
   // sh: multiplier shifting out (mult) or dividend out / quotient in (div).
   logic [WIDTH-1:0] sh_q, sh_d;
   // opb: multiplicand or divisor magnitude.
   logic [WIDTH:0]   opb_q, opb_d;
   logic             is_div_q, is_div_d;
   logic             neg_lo_q, neg_lo_d;
   logic             neg_hi_q, neg_hi_d;
   logic             div_zero_q, div_zero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   mdu_op_t          op;
   logic             signed_op;
   logic             sa, sb;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH+1:0] mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign busy_o = (state_q != StIdle);
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

   // Operand magnitudes, datapath step results and sign-corrected results.
   always_comb begin
      op        = mdu_op_t'(op_i);
      signed_op = (op == OpMult) || (op == OpDiv);
      sa        = signed_op & a_i[WIDTH-1];
      sb        = signed_op & b_i[WIDTH-1];
      // Unsigned view of the negation covers the most-negative value too.
      a_mag     = sa ? (WIDTH'(0) - a_i) : a_i;
      b_mag     = sb ? (WIDTH'(0) - b_i) : b_i;

      mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {1'b0, opb_q};

      prod_fix  = neg_lo_q ? (2*WIDTH)'(0) - {acc_q[WIDTH-1:0], sh_q}
                           : {acc_q[WIDTH-1:0], sh_q};
      quo_fix   = neg_lo_q ? (WIDTH'(0) - sh_q) : sh_q;
      rem_fix   = neg_hi_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
   end

   // Next-state logic: IDLE accepts work, CALC iterates, FINISH commits.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      sh_d       = sh_q;
      opb_d      = opb_q;
      is_div_d   = is_div_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i && !cancel_i) begin
               case (op)
                  OpMult, OpMultu, OpDiv, OpDivu: begin
                     state_d    = StCalc;
                     cnt_d      = '0;
                     acc_d      = '0;
                     sh_d       = a_mag;
                     opb_d      = {1'b0, b_mag};
                     is_div_d   = (op == OpDiv) || (op == OpDivu);
                     // Product/quotient sign; remainder follows the dividend.
                     neg_lo_d   = sa ^ sb;
                     neg_hi_d   = sa;
                     div_zero_d = (b_i == '0);
                  end
                  OpMthi:  hi_d = a_i;
                  OpMtlo:  lo_d = a_i;
                  default: ;
               endcase
            end
         end
         StCalc: begin
            if (cancel_i) begin
               state_d = StIdle;
            end else begin
               if (is_div_q) begin
                  if (!div_diff[WIDTH+1]) begin
                     acc_d = div_diff[WIDTH:0];
                     sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_d = div_shift;
                     sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_d = mul_sum[WIDTH+1:1];
                  sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  state_d = StFinish;
               end
            end
         end
         StFinish: begin
            state_d = StIdle;
            if (!cancel_i) begin
               if (is_div_q) begin
                  // Zero divisor: remainder path already yields the dividend.
                  lo_d = div_zero_q ? '1 : quo_fix;
                  hi_d = rem_fix;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
               done_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         sh_q       <= '0;
         opb_q      <= '0;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         sh_q       <= sh_d;
         opb_q      <= opb_d;
         is_div_q   <= is_div_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        cancel;
   logic        busy, done;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;
   int busy_cnt, done_n, bad_overlap, done_seen;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (start),
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .cancel_i (cancel),
      .busy_o   (busy),
      .done_o   (done),
      .hi_o     (hi),
      .lo_o     (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns at the first falling edge after acceptance.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts busy cycles until done; done_n is the falling-edge index (1 = first after accept).
   task automatic wait_done(output int nbusy, output int ndone, output int overlap);
      nbusy   = 0;
      ndone   = -1;
      overlap = 0;
      for (int n = 1; n <= 100; n++) begin
         if (busy) nbusy++;
         if (busy && done) overlap++;
         if (done) begin
            ndone = n;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      issue(o, x, y);
      wait_done(busy_cnt, done_n, bad_overlap);
      chk({tag, "_done_at"}, 64'(done_n), 64'd34);
      chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
      chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      op     = 3'd0;
      a      = '0;
      b      = '0;
      cancel = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // MULT -3 * 5, with latency/busy-length/pulse checks
      issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0005);
      wait_done(busy_cnt, done_n, bad_overlap);
      chk("mult_done_at", 64'(done_n), 64'd34);
      chk("mult_busy_cycles", 64'(busy_cnt), 64'd33);
      chk("mult_overlap", 64'(bad_overlap), 64'd0);
      chk("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
      chk("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF1);
      @(negedge clk);
      chk("mult_done_pulse", {63'd0, done}, 64'd0);

      run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("div_negb", 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("divu_zero", 3'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
      run_op("div_zero", 3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

      // MTHI / MTLO: immediate write, never busy
      issue(3'd4, 32'h0000_1234, 32'h0);
      chk("mthi_hi", {32'd0, hi}, 64'h1234);
      chk("mthi_busy", {63'd0, busy}, 64'd0);
      chk("mthi_done", {63'd0, done}, 64'd0);
      issue(3'd5, 32'h0000_5678, 32'h0);
      chk("mtlo_lo", {32'd0, lo}, 64'h5678);

      // cancel in IDLE suppresses MTHI; reserved op is ignored
      cancel = 1'b1;
      issue(3'd4, 32'h0000_DEAD, 32'h0);
      cancel = 1'b0;
      chk("idle_cancel_hi", {32'd0, hi}, 64'h1234);
      issue(3'd6, 32'h0000_0007, 32'h0000_0006);
      chk("reserved_busy", {63'd0, busy}, 64'd0);
      chk("reserved_lo", {32'd0, lo}, 64'h5678);

      // MULT 7*6 cancelled at cycle 10, with an ignored MTLO start mid-op
      issue(3'd0, 32'h7, 32'h6);
      repeat (3) @(negedge clk);
      issue(3'd5, 32'h0000_BEEF, 32'h0);
      repeat (5) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", {63'd0, busy}, 64'd0);
      chk("cancel_done", {63'd0, done}, 64'd0);
      chk("cancel_hi", {32'd0, hi}, 64'h1234);
      chk("cancel_lo", {32'd0, lo}, 64'h5678);
      done_seen = 0;
      for (int n = 0; n < 40; n++) begin
         if (done) done_seen++;
         @(negedge clk);
      end
      chk("cancel_no_done", 64'(done_seen), 64'd0);

      run_op("mult_small", 3'd0, 32'h7, 32'h6, 32'h0, 32'h2A);

      // cancel while in FINISH beats the write
      issue(3'd1, 32'h0000_0100, 32'h0000_0100);
      repeat (32) @(negedge clk);
      chk("fin_busy_before", {63'd0, busy}, 64'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("fin_cancel_busy", {63'd0, busy}, 64'd0);
      chk("fin_cancel_done", {63'd0, done}, 64'd0);
      chk("fin_cancel_hi", {32'd0, hi}, 64'h0);
      chk("fin_cancel_lo", {32'd0, lo}, 64'h2A);

      // reset during CALC clears everything
      issue(3'd0, 32'h0000_0003, 32'h0000_0003);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_calc_busy", {63'd0, busy}, 64'd0);
      chk("rst_calc_done", {63'd0, done}, 64'd0);
      chk("rst_calc_hi", {32'd0, hi}, 64'h0);
      chk("rst_calc_lo", {32'd0, lo}, 64'h0);

      run_op("post_rst_multu", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
